// File: rtl/square_accumulator.sv
// ============================================================================
// Module: square_accumulator
//
// Purpose
//   Consumes a stream of 3-bit unsigned operands, squares each one (6-bit
//   result, at most 49) and adds the squares over a frame of FRAME_LEN
//   operands. The frame total is presented on a valid/ready output and held
//   there until downstream takes it. The result gives the energy
//   (sum of squares) of each frame of a 3-bit sample stream.
//
// Parameters
//   FRAME_LEN  operands per frame (1..255)
//   ACC_W      accumulator / result width in bits (6..16)
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operand on a is valid
//   in_ready   out  1      operand is accepted this cycle (registered)
//   a          in   3      unsigned operand, a[0] is the LSB
//   out_valid  out  1      sum holds a completed frame total
//   out_ready  in   1      downstream takes sum this cycle
//   sum        out  ACC_W  sum of squares of the frame
//   ovf        out  1      frame total exceeded 2^ACC_W-1 (valid with out_valid)
//
// Build option
//   SQUARE_ACCUMULATOR_SAT_EN  defined   : the accumulator saturates at
//                                          2^ACC_W-1 once a frame overflows
//                              undefined : the accumulator wraps modulo 2^ACC_W
//   The ovf flag behaves identically in both builds.
// ============================================================================
module square_accumulator #(
    parameter int FRAME_LEN = 4,
    parameter int ACC_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       a,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    // Index of the operand that closes a frame.
    localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

    logic [0:0]       r_state;
    logic             r_inReady;
    logic [ACC_W-1:0] r_acc;
    logic [7:0]       r_cnt;
    logic             r_ovfSticky;
    logic [ACC_W-1:0] r_sum;
    logic             r_ovf;

    logic [5:0]       w_sq;
    logic [ACC_W:0]   w_addWide;
    logic             w_carry;
    logic             w_frameOvf;
    logic [ACC_W-1:0] w_accNext;
    logic             w_accept;
    logic             w_lastOp;
    logic [0:0]       w_stateNext;

    // Both factors are widened to 6 bits first so the product is not
    // truncated to the 3-bit operand width.
    assign w_sq = {3'b000, a} * {3'b000, a};

    // One spare bit above the accumulator catches the carry of every add.
    assign w_addWide  = {1'b0, r_acc} + {{(ACC_W - 5){1'b0}}, w_sq};
    assign w_carry    = w_addWide[ACC_W];
    assign w_frameOvf = r_ovfSticky | w_carry;

`ifdef SQUARE_ACCUMULATOR_SAT_EN
    // Once the frame has overflowed the accumulator pins at full scale,
    // even if later operands are zero.
    assign w_accNext = w_frameOvf ? {ACC_W{1'b1}} : w_addWide[ACC_W-1:0];
`else
    assign w_accNext = w_addWide[ACC_W-1:0];
`endif

    assign w_accept = in_valid & r_inReady & (r_state == ST_ACCUM);
    assign w_lastOp = (r_cnt == LAST_IDX);

    // Next-state logic: a frame closes on its last accepted operand and the
    // held total is released by out_ready. out_ready is ignored in ACCUM.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_ACCUM: begin
                if (w_accept && w_lastOp) begin
                    w_stateNext = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    w_stateNext = ST_ACCUM;
                end
            end
            default: w_stateNext = ST_ACCUM;
        endcase
    end

    // in_ready is registered from the next state so it never depends
    // combinationally on out_ready. It stays low through reset and rises on
    // the first clock after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_ACCUM;
            r_inReady   <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovfSticky <= 1'b0;
            r_sum       <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_inReady <= (w_stateNext == ST_ACCUM);
            if (w_accept) begin
                if (w_lastOp) begin
                    r_sum       <= w_accNext;
                    r_ovf       <= w_frameOvf;
                    r_acc       <= '0;
                    r_cnt       <= '0;
                    r_ovfSticky <= 1'b0;
                end else begin
                    r_acc       <= w_accNext;
                    r_cnt       <= r_cnt + 8'd1;
                    r_ovfSticky <= w_frameOvf;
                end
            end
        end
    end

    assign in_ready  = r_inReady;
    assign out_valid = (r_state == ST_HOLD);
    assign sum       = r_sum;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_square_accumulator.sv
// ============================================================================
// Testbench: tb_square_accumulator
//
// Two instances are exercised: dut4 (FRAME_LEN=4, ACC_W=8) and dut8
// (FRAME_LEN=8, ACC_W=8). Stimulus pushes the hand-computed frame total into
// a per-instance queue; a monitor forked from the main process pops and
// compares whenever an instance completes an output handshake.
// ============================================================================
module tb_square_accumulator;

    typedef struct {
        logic [7:0] sum;
        logic       ovf;
    } exp_t;

`ifdef SQUARE_ACCUMULATOR_SAT_EN
    localparam logic [7:0] OVF_SUM = 8'd255;
`else
    localparam logic [7:0] OVF_SUM = 8'd136;
`endif

    logic       clk = 1'b0;
    logic       rst_n;

    logic       iv4, ir4, ov4, or4, ovf4;
    logic [2:0] a4;
    logic [7:0] sum4;

    logic       iv8, ir8, ov8, or8, ovf8;
    logic [2:0] a8;
    logic [7:0] sum8;

    exp_t q4[$];
    exp_t q8[$];

    int vecCount  = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    square_accumulator #(.FRAME_LEN(4), .ACC_W(8)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv4), .in_ready(ir4), .a(a4),
        .out_valid(ov4), .out_ready(or4), .sum(sum4), .ovf(ovf4)
    );

    square_accumulator #(.FRAME_LEN(8), .ACC_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv8), .in_ready(ir8), .a(a8),
        .out_valid(ov8), .out_ready(or8), .sum(sum8), .ovf(ovf8)
    );

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        vecCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Presents one operand to the selected instance and holds it until the
    // instance accepts it, then drops in_valid just after the accepting edge.
    task automatic applyStimulus(input bit sel, input logic [2:0] val);
        int waitCycles = 0;
        if (sel) begin iv8 = 1'b1; a8 = val; end
        else     begin iv4 = 1'b1; a4 = val; end
        forever begin
            @(negedge clk);
            if ((sel ? ir8 : ir4) === 1'b1) break;
            waitCycles++;
            if (waitCycles > 100) begin
                vecCount++;
                failCount++;
                $display("[TB] FAIL accept timeout: got in_ready=0, expected 1 within 100 cycles");
                break;
            end
        end
        @(posedge clk);
        #1;
        if (sel) iv8 = 1'b0;
        else     iv4 = 1'b0;
    endtask

    task automatic monitorOutputs();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (ov4 === 1'b1 && or4 === 1'b1) begin
                    if (q4.size() == 0) begin
                        vecCount++;
                        failCount++;
                        $display("[TB] FAIL dut4 unexpected output: got sum=%0d, expected none", sum4);
                    end else begin
                        e = q4.pop_front();
                        checkOutput("dut4 sum", 16'(sum4), 16'(e.sum));
                        checkOutput("dut4 ovf", 16'(ovf4), 16'(e.ovf));
                    end
                end
                if (ov8 === 1'b1 && or8 === 1'b1) begin
                    if (q8.size() == 0) begin
                        vecCount++;
                        failCount++;
                        $display("[TB] FAIL dut8 unexpected output: got sum=%0d, expected none", sum8);
                    end else begin
                        e = q8.pop_front();
                        checkOutput("dut8 sum", 16'(sum8), 16'(e.sum));
                        checkOutput("dut8 ovf", 16'(ovf8), 16'(e.ovf));
                    end
                end
            end
        end
    endtask

    // Frames of four operands for dut4 with hand-computed totals:
    // 1+4+9+16 = 30 and 36+36+49+49 = 170.
    logic [2:0] frameTab [2][4] = '{'{3'd1, 3'd2, 3'd3, 3'd4},
                                    '{3'd6, 3'd6, 3'd7, 3'd7}};
    logic [7:0] frameSum [2]    = '{8'd30, 8'd170};

    initial begin
        rst_n = 1'b0;
        iv4 = 1'b0; a4 = 3'd0; or4 = 1'b0;
        iv8 = 1'b0; a8 = 3'd0; or8 = 1'b0;

        fork
            monitorOutputs();
        join_none

        // Reset values, then in_ready rising only after the first edge
        // following release.
        #12;
        checkOutput("reset out_valid", 16'(ov4), 16'd0);
        checkOutput("reset sum", 16'(sum4), 16'd0);
        checkOutput("reset ovf", 16'(ovf4), 16'd0);
        checkOutput("reset in_ready", 16'(ir4), 16'd0);
        #1 rst_n = 1'b1;
        #1;
        checkOutput("in_ready before first edge", 16'(ir4), 16'd0);
        @(posedge clk);
        #1;
        checkOutput("dut4 in_ready after release", 16'(ir4), 16'd1);
        checkOutput("dut8 in_ready after release", 16'(ir8), 16'd1);

        // Basic frame 9+25+49+4 = 87, taken immediately.
        or4 = 1'b1;
        q4.push_back('{sum: 8'd87, ovf: 1'b0});
        applyStimulus(1'b0, 3'd3);
        applyStimulus(1'b0, 3'd5);
        applyStimulus(1'b0, 3'd7);
        applyStimulus(1'b0, 3'd2);
        @(negedge clk);
        checkOutput("basic out_valid latency", 16'(ov4), 16'd1);
        checkOutput("basic in_ready bubble", 16'(ir4), 16'd0);
        @(negedge clk);
        checkOutput("basic in_ready after bubble", 16'(ir4), 16'd1);
        checkOutput("basic out_valid dropped", 16'(ov4), 16'd0);

        // Backpressure: the total is held while an operand waits.
        @(posedge clk);
        #1 or4 = 1'b0;
        q4.push_back('{sum: 8'd87, ovf: 1'b0});
        applyStimulus(1'b0, 3'd3);
        applyStimulus(1'b0, 3'd5);
        applyStimulus(1'b0, 3'd7);
        applyStimulus(1'b0, 3'd2);
        iv4 = 1'b1;
        a4  = 3'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("hold out_valid", 16'(ov4), 16'd1);
            checkOutput("hold sum stable", 16'(sum4), 16'd87);
            checkOutput("hold in_ready", 16'(ir4), 16'd0);
        end
        @(posedge clk);
        #1 or4 = 1'b1;

        // The waiting a=1 opens a gapped frame of four ones: total 4.
        q4.push_back('{sum: 8'd4, ovf: 1'b0});
        applyStimulus(1'b0, 3'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            applyStimulus(1'b0, 3'd1);
        end

        // Further patterns from the table.
        for (int f = 0; f < 2; f++) begin
            q4.push_back('{sum: frameSum[f], ovf: 1'b0});
            for (int k = 0; k < 4; k++) applyStimulus(1'b0, frameTab[f][k]);
        end

        // Overflow on dut8: 8 x 49 = 392, then a clean all-zero frame.
        or8 = 1'b1;
        q8.push_back('{sum: OVF_SUM, ovf: 1'b1});
        for (int k = 0; k < 8; k++) applyStimulus(1'b1, 3'd7);
        q8.push_back('{sum: 8'd0, ovf: 1'b0});
        for (int k = 0; k < 8; k++) applyStimulus(1'b1, 3'd0);

        // Reset mid-frame: the two sevens are discarded.
        applyStimulus(1'b0, 3'd7);
        applyStimulus(1'b0, 3'd7);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        checkOutput("mid reset in_ready", 16'(ir4), 16'd0);
        checkOutput("mid reset out_valid", 16'(ov4), 16'd0);
        checkOutput("mid reset sum", 16'(sum4), 16'd0);
        checkOutput("mid reset ovf", 16'(ovf4), 16'd0);
        #1 rst_n = 1'b1;
        q4.push_back('{sum: 8'd4, ovf: 1'b0});
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, 3'd1);

        // Let the monitor drain what remains, within a bounded wait.
        for (int i = 0; i < 50; i++) begin
            if (q4.size() == 0 && q8.size() == 0) break;
            @(posedge clk);
        end
        @(negedge clk);
        checkOutput("dut4 frames outstanding", 16'(q4.size()), 16'd0);
        checkOutput("dut8 frames outstanding", 16'(q8.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
        $finish;
    end

endmodule
